// File: rtl/rr_burst_sched_pkg.sv
// Shared definitions for the round-robin arbiter family: scheduler states and
// the index-width helper.
package rr_burst_sched_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Binary index width needed to name one of n requesters (at least 1 bit).
    function automatic int unsigned rr_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_burst_sched_pick.sv
// Rotate-priority encoder: returns the first set bit of i_elig scanning from
// i_ptr upward with wrap-around. i_ptr must be below N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_index
);

    always_comb begin : p_scan
        int unsigned j;
        j       = 0;
        o_found = 1'b0;
        o_index = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_found && i_elig[j]) begin
                o_found = 1'b1;
                o_index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_burst_sched.sv
// Round-robin burst scheduler: one owner at a time holds the shared resource
// for up to max_burst beats, then ownership rotates to the next eligible requester.
module rr_burst_sched
    import rr_burst_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 4,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_n,
    input  logic          enable,
    input  logic [N-1:0]  request,
    input  logic [N-1:0]  mask,
    input  logic [CW-1:0] max_burst,
    input  logic          res_ready,
    output logic          granted,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_index,
    output logic          beat,
    output logic [CW-1:0] beat_cnt
);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;

    logic [N-1:0]  w_elig;
    logic          w_own;
    logic          w_beat;
    logic          w_last_beat;
    logic          w_end;
    logic [IW-1:0] w_ptr_adv;
    logic [IW-1:0] w_pick_ptr;
    logic          w_pick_found;
    logic [IW-1:0] w_pick_idx;

    assign w_elig      = request & ~mask;
    assign w_own       = (r_state == ST_OWN);
    assign w_beat      = enable & w_own & request[r_owner] & res_ready & ~mask[r_owner];
    assign w_last_beat = w_beat && (max_burst != '0) && (r_beat_cnt == max_burst - CW'(1));
    assign w_end       = enable & w_own & (~request[r_owner] | mask[r_owner] | w_last_beat);

    // On burst end the owner drops to lowest priority by moving the pointer past it,
    // so the same-cycle re-arbitration naturally lets a lone requester win again.
    assign w_ptr_adv  = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);
    assign w_pick_ptr = w_end ? w_ptr_adv : r_ptr;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (w_pick_ptr),
        .o_found (w_pick_found),
        .o_index (w_pick_idx)
    );

    // Next-state logic for ownership, burst counter and priority pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_beat_cnt;
        w_grant_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_pick_found) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ST_OWN: begin
                if (w_end) begin
                    w_ptr_nxt = w_ptr_adv;
                    w_cnt_nxt = '0;
                    if (w_pick_found) begin
                        w_owner_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = '0;
                    end
                end else if (w_beat) begin
                    w_cnt_nxt = r_beat_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_state_nxt == ST_OWN) begin
            w_grant_nxt[w_owner_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_grant    <= '0;
        end else if (!init_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_grant    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    assign granted     = w_own;
    assign grant       = r_grant;
    assign grant_index = r_owner;
    assign beat        = w_beat;
    assign beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_rr_burst_sched.sv
// Bench for rr_burst_sched: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_rr_burst_sched;
    import rr_burst_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = rr_idx_w(N);
    localparam int unsigned RW = 1 + N + IW + CW;

    logic          clk;
    logic          rst;
    logic          init_n;
    logic          enable;
    logic [N-1:0]  request;
    logic [N-1:0]  mask;
    logic [CW-1:0] max_burst;
    logic          res_ready;
    logic          granted;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_index;
    logic          beat;
    logic [CW-1:0] beat_cnt;

    int n_checks;
    int n_fail;

    // Behavioural model state
    bit m_own;
    int m_owner;
    int m_ptr;
    int m_cnt;

    logic obs_beat;
    logic exp_beat;

    rr_burst_sched #(
        .N  (N),
        .CW (CW),
        .IW (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_n      (init_n),
        .enable      (enable),
        .request     (request),
        .mask        (mask),
        .max_burst   (max_burst),
        .res_ready   (res_ready),
        .granted     (granted),
        .grant       (grant),
        .grant_index (grant_index),
        .beat        (beat),
        .beat_cnt    (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] e, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (e[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic model_beat();
        return enable && m_own && request[m_owner] && res_ready && !mask[m_owner];
    endfunction

    function automatic logic [RW-1:0] exp_regs();
        logic [N-1:0] g;
        g = '0;
        if (m_own) g[m_owner] = 1'b1;
        return {m_own, g, IW'(m_owner), CW'(m_cnt)};
    endfunction

    function automatic logic [RW-1:0] obs_regs();
        return {granted, grant, grant_index, beat_cnt};
    endfunction

    task automatic model_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        int   p;
        logic b;
        b = model_beat();
        if (!init_n) begin
            model_reset();
        end else if (!enable) begin
            // frozen
        end else if (!m_own) begin
            p = model_pick(request & ~mask, m_ptr);
            if (p >= 0) begin
                m_own   = 1'b1;
                m_owner = p;
                m_cnt   = 0;
            end
        end else if (!request[m_owner] || mask[m_owner] ||
                     (b && max_burst != 0 && m_cnt == int'(max_burst) - 1)) begin
            m_ptr = (m_owner + 1) % N;
            m_cnt = 0;
            p     = model_pick(request & ~mask, m_ptr);
            if (p >= 0) begin
                m_owner = p;
            end else begin
                m_own   = 1'b0;
                m_owner = 0;
            end
        end else if (b) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
    endtask

    // One clock: sample the combinational beat, advance model and DUT together.
    task automatic tick();
        #1;
        obs_beat = beat;
        exp_beat = model_beat();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        init_n    = 1'b1;
        enable    = 1'b1;
        request   = '0;
        mask      = '0;
        max_burst = '0;
        res_ready = 1'b1;
        rst       = 1'b1;
        model_reset();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs_regs() !== RW'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_regs(), RW'(0));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs_regs() !== exp_regs() || obs_regs() !== RW'(0)) begin
                n_fail++;
                $display("FAIL reset_idle: got %h expected %h", obs_regs(), RW'(0));
            end
        end
    endtask

    task automatic test_basic_rr();
        do_reset();
        request   = 4'b1111;
        max_burst = 4'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (obs_beat !== exp_beat) begin
                n_fail++;
                $display("FAIL rr_beat[%0d]: got %b expected %b", i, obs_beat, exp_beat);
            end
            n_checks++;
            if (obs_regs() !== exp_regs() || !granted || grant_index !== IW'((i / 2) % N)) begin
                n_fail++;
                $display("FAIL rr_owner[%0d]: got %h idx %0d expected %h idx %0d",
                         i, obs_regs(), grant_index, exp_regs(), (i / 2) % N);
            end
        end
    endtask

    task automatic test_stall();
        logic rdy [5];
        int   ec  [5];
        int   ei  [5];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ec  = '{1, 1, 1, 2, 0};
        ei  = '{1, 1, 1, 1, 2};
        do_reset();
        request   = 4'b0110;
        max_burst = 4'd3;
        tick();
        n_checks++;
        if (grant_index !== IW'(1) || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL stall_first_owner: got %h expected %h", obs_regs(), exp_regs());
        end
        for (int i = 0; i < 5; i++) begin
            res_ready = rdy[i];
            tick();
            n_checks++;
            if (obs_beat !== exp_beat || obs_beat !== rdy[i]) begin
                n_fail++;
                $display("FAIL stall_beat[%0d]: got %b expected %b", i, obs_beat, rdy[i]);
            end
            n_checks++;
            if (obs_regs() !== exp_regs() || beat_cnt !== CW'(ec[i]) || grant_index !== IW'(ei[i])) begin
                n_fail++;
                $display("FAIL stall_count[%0d]: got cnt %0d idx %0d expected cnt %0d idx %0d",
                         i, beat_cnt, grant_index, ec[i], ei[i]);
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_release_mask();
        do_reset();
        request = 4'b0100;
        tick();
        tick();
        n_checks++;
        if (grant_index !== IW'(2) || beat_cnt !== CW'(1) || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL release_setup: got %h expected %h", obs_regs(), exp_regs());
        end
        request = 4'b1000;
        tick();
        n_checks++;
        if (obs_beat !== 1'b0 || exp_beat !== 1'b0) begin
            n_fail++;
            $display("FAIL release_no_beat: got %b expected 0", obs_beat);
        end
        n_checks++;
        if (grant_index !== IW'(3) || beat_cnt !== '0 || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL release_next_owner: got %h expected %h", obs_regs(), exp_regs());
        end
        tick();
        mask = 4'b1000;
        tick();
        n_checks++;
        if (obs_beat !== 1'b0 || granted !== 1'b0 || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL mask_end: got beat %b regs %h expected beat 0 regs %h",
                     obs_beat, obs_regs(), exp_regs());
        end
        request   = 4'b1111;
        max_burst = 4'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (obs_regs() !== exp_regs() || (granted && grant_index === IW'(3))) begin
                n_fail++;
                $display("FAIL mask_skip[%0d]: got %h expected %h", i, obs_regs(), exp_regs());
            end
        end
        mask = '0;
    endtask

    task automatic test_unlimited_enable();
        do_reset();
        request = 4'b0001;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (obs_regs() !== exp_regs() || beat_cnt !== CW'((k + 1) % 16) ||
                !granted || grant !== 4'b0001) begin
                n_fail++;
                $display("FAIL unlimited_cnt[%0d]: got cnt %0d grant %b expected cnt %0d grant 0001",
                         k, beat_cnt, grant, (k + 1) % 16);
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs_beat !== 1'b0 || obs_regs() !== exp_regs() || beat_cnt !== CW'(4)) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got beat %b cnt %0d expected beat 0 cnt 4",
                         k, obs_beat, beat_cnt);
            end
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if (obs_regs() !== exp_regs() || beat_cnt !== CW'(5)) begin
            n_fail++;
            $display("FAIL unfreeze: got cnt %0d expected 5", beat_cnt);
        end
    endtask

    task automatic test_init();
        do_reset();
        request   = 4'b0110;
        max_burst = 4'd1;
        tick();
        tick();
        n_checks++;
        if (grant_index !== IW'(2) || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL init_setup: got %h expected %h", obs_regs(), exp_regs());
        end
        request = 4'b1111;
        init_n  = 1'b0;
        tick();
        n_checks++;
        if (obs_regs() !== RW'(0) || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL init_idle: got %h expected %h", obs_regs(), RW'(0));
        end
        init_n = 1'b1;
        tick();
        n_checks++;
        if (!granted || grant !== 4'b0001 || grant_index !== '0 || obs_regs() !== exp_regs()) begin
            n_fail++;
            $display("FAIL init_first_grant: got %h expected %h", obs_regs(), exp_regs());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        request   = 4'b1111;
        max_burst = '0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs_regs() !== RW'(0) || beat !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h beat %b expected 0", obs_regs(), beat);
        end
        #2;
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs_regs() !== exp_regs() || grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_release: got %h expected %h", obs_regs(), exp_regs());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            request   = N'($urandom);
            mask      = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            max_burst = CW'($urandom_range(0, 3));
            res_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            init_n    = ($urandom_range(0, 49) != 0);
            tick();
            n_checks++;
            if (obs_beat !== exp_beat) begin
                n_fail++;
                $display("FAIL rand_beat[%0d]: got %b expected %b", i, obs_beat, exp_beat);
            end
            n_checks++;
            if (obs_regs() !== exp_regs()) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: got %h expected %h", i, obs_regs(), exp_regs());
            end
        end
        init_n = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_rr();
        test_stall();
        test_release_mask();
        test_unlimited_enable();
        test_init();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
